mmio_uart_tx: RTL and testbench

MMIO_UART_TX -- requirements
Module: mmio_uart_tx

---
 rtl/mmio_uart_tx_pkg.sv | 46 ++++
 rtl/uart_tx_fifo.sv | 80 ++++++++
 rtl/mmio_uart_tx.sv | 208 ++++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_uart_tx_pkg.sv
// ---------------------------------------------------------------------------
// mmio_uart_tx_pkg
// Shared definitions for the memory-mapped UART transmitter:
//   - transmit FSM state encoding
//   - register offsets within the 16-byte window (word index = addr[3:2])
//   - STATUS register bit positions and a helper that packs the STATUS word
// ---------------------------------------------------------------------------
package mmio_uart_tx_pkg;

  typedef logic [1:0] tx_state_t;

  localparam tx_state_t ST_IDLE  = 2'd0;
  localparam tx_state_t ST_START = 2'd1;
  localparam tx_state_t ST_DATA  = 2'd2;
  localparam tx_state_t ST_STOP  = 2'd3;

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CLEAR  = 2'd2;

  localparam int STAT_BUSY      = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_EMPTY     = 2;
  localparam int STAT_OVERFLOW  = 3;
  localparam int STAT_COUNT_LSB = 4;
  localparam int STAT_COUNT_W   = 5;

  // Builds the STATUS read word; every bit not listed here reads as zero.
  function automatic logic [31:0] pack_status(
    input logic                    busy,
    input logic                    full,
    input logic                    empty,
    input logic                    overflow,
    input logic [STAT_COUNT_W-1:0] count
  );
    logic [31:0] word;
    word                                  = '0;
    word[STAT_BUSY]                       = busy;
    word[STAT_FULL]                       = full;
    word[STAT_EMPTY]                      = empty;
    word[STAT_OVERFLOW]                   = overflow;
    word[STAT_COUNT_LSB +: STAT_COUNT_W]  = count;
    return word;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
// Byte FIFO feeding the UART transmitter. Power-of-two depth so the read and
// write pointers wrap naturally. The head byte is presented combinationally on
// rdata so the consumer can load it on the same edge it pops.
//
// Ports:
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset (pointers and count to zero)
//   push   in   write request; accepted when not full, or when full and pop
//               is taken in the same cycle
//   pop    in   read request; ignored when empty
//   wdata  in   [7:0] byte to write
//   rdata  out  [7:0] byte at the head of the FIFO
//   full   out  count == DEPTH
//   empty  out  count == 0
//   count  out  number of stored bytes, 0..DEPTH
// ---------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic [7:0]                   wdata,
  output logic [7:0]                   rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign rdata = mem[rd_ptr];

  // A push into a full FIFO is still safe when the head leaves on the same
  // edge: the write slot equals the read slot, and the old byte is consumed
  // from rdata before the edge overwrites it.
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wdata;
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// ---------------------------------------------------------------------------
// mmio_uart_tx
// Memory-mapped 8N1 UART transmitter with a small transmit FIFO.
// Register window of 16 bytes at BASE_ADDR, word index = Mem_WrAddr[3:2]:
//   0 TXDATA  write pushes Mem_WrData[7:0]; reads 0
//   1 STATUS  {count[8:4], overflow[3], empty[2], full[1], busy[0]}
//   2 CLEAR   write clears the sticky overflow flag; reads 0
//   3 reserved
//
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   asynchronous active-low reset; release is resynchronised
//   MemWrite    in   CPU store strobe
//   Mem_WrAddr  in   [31:0] CPU address for loads and stores
//   Mem_WrData  in   [31:0] CPU store data
//   sel         out  address falls inside the register window (combinational)
//   rd_data     out  [31:0] register read data, zero when sel is low
//   tx          out  serial line, idle high, registered
//   irq         out  registered; high while the FIFO is empty and FSM is idle
// ---------------------------------------------------------------------------
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0400,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] Mem_WrAddr,
  input  logic [31:0] Mem_WrData,
  output logic        sel,
  output logic [31:0] rd_data,
  output logic        tx,
  output logic        irq
);

  import mmio_uart_tx_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [1:0]    rst_sync;
  logic          rst_n;

  logic [1:0]    offset;
  logic          push_req;
  logic          clear_req;
  logic          push_ok;
  logic          push_rej;
  logic          pop;

  logic [7:0]    fifo_rdata;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;

  tx_state_t     state;
  logic [BW-1:0] baud_cnt;
  logic          baud_wrap;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_reg;
  logic          overflow;

  logic          next_idle;
  logic          will_empty;
  logic          unused_wdata_hi;

  // Reset asserts everywhere at once through the async clear of this pair,
  // but internal logic only leaves reset two edges after the pin is released,
  // so no flop sees the release close to its active edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign rst_n = rst_sync[1];

  // Address decode and register strobes.
  assign sel       = (Mem_WrAddr >= BASE_ADDR) && (Mem_WrAddr <= (BASE_ADDR + 32'd15));
  assign offset    = Mem_WrAddr[3:2];
  assign push_req  = sel && MemWrite && (offset == REG_TXDATA);
  assign clear_req = sel && MemWrite && (offset == REG_CLEAR);

  // The FSM only takes a byte while idle; a full FIFO still accepts a push
  // on that same edge because a slot is freed by the pop.
  assign pop      = (state == ST_IDLE) && !fifo_empty;
  assign push_ok  = push_req && (!fifo_full || pop);
  assign push_rej = push_req && !push_ok;

  assign unused_wdata_hi = ^Mem_WrData[31:8];

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_req),
    .pop   (pop),
    .wdata (Mem_WrData[7:0]),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Register read mux; only STATUS returns data.
  always_comb begin
    rd_data = '0;
    if (sel && (offset == REG_STATUS)) begin
      rd_data = pack_status(state != ST_IDLE, fifo_full, fifo_empty, overflow,
                            STAT_COUNT_W'(fifo_count));
    end
  end

  // Sticky overflow: a rejected push in the same cycle as a CLEAR write wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (push_rej) begin
      overflow <= 1'b1;
    end else if (clear_req) begin
      overflow <= 1'b0;
    end
  end

  assign baud_wrap = (baud_cnt == BW'(CLKS_PER_BIT - 1));

  // Transmit FSM. tx is registered and always loaded with the level of the
  // state being entered, so each bit is on the line for exactly CLKS_PER_BIT
  // cycles and the single IDLE cycle between frames keeps tx high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      tx        <= 1'b1;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            shift_reg <= fifo_rdata;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            tx        <= 1'b0;
            state     <= ST_START;
          end
        end
        ST_START: begin
          if (baud_wrap) begin
            baud_cnt <= '0;
            tx       <= shift_reg[0];
            state    <= ST_DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (baud_wrap) begin
            baud_cnt  <= '0;
            shift_reg <= shift_reg >> 1;
            bit_cnt   <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) begin
              tx    <= 1'b1;
              state <= ST_STOP;
            end else begin
              tx <= shift_reg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (baud_wrap) begin
            baud_cnt <= '0;
            tx       <= 1'b1;
            state    <= ST_IDLE;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // irq is computed from the values the FSM and FIFO will hold after this
  // edge, so the registered output lines up with the state it describes.
  assign next_idle  = ((state == ST_IDLE) && fifo_empty) ||
                      ((state == ST_STOP) && baud_wrap);
  assign will_empty = !push_ok &&
                      (fifo_empty || ((fifo_count == CW'(1)) && pop));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq <= 1'b1;
    end else begin
      irq <= next_idle && will_empty;
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_mmio_uart_tx
// Self-checking bench for mmio_uart_tx (CLKS_PER_BIT=4, FIFO_DEPTH=4).
// A behavioural model tracks a byte queue and the elapsed time of the frame
// on the line; tx is predicted from the bit slot the elapsed time falls in.
// ---------------------------------------------------------------------------
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE = 32'h0000_0400;
  localparam int          N    = 4;
  localparam int          D    = 4;

  logic        clk        = 1'b0;
  logic        reset      = 1'b1;
  logic        MemWrite   = 1'b0;
  logic [31:0] Mem_WrAddr = '0;
  logic [31:0] Mem_WrData = '0;
  logic        sel;
  logic [31:0] rd_data;
  logic        tx;
  logic        irq;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0] mq[$];
  bit         m_active;
  int         m_t;
  logic [7:0] m_byte;
  bit         m_ovf;

  bit         prev_tx = 1'b1;
  int         fall_q[$];

  mmio_uart_tx #(
    .BASE_ADDR    (BASE),
    .CLKS_PER_BIT (N),
    .FIFO_DEPTH   (D)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .MemWrite   (MemWrite),
    .Mem_WrAddr (Mem_WrAddr),
    .Mem_WrData (Mem_WrData),
    .sel        (sel),
    .rd_data    (rd_data),
    .tx         (tx),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  function automatic void modelReset();
    mq.delete();
    m_active = 1'b0;
    m_t      = 0;
    m_byte   = '0;
    m_ovf    = 1'b0;
  endfunction

  // Frame layout in time: N cycles start(0), 8*N data LSB first, N stop(1).
  function automatic logic modelTx();
    if (!m_active)    return 1'b1;
    if (m_t < N)      return 1'b0;
    if (m_t < 9 * N)  return m_byte[(m_t / N) - 1];
    return 1'b1;
  endfunction

  function automatic bit modelSel(input logic [31:0] a);
    return (a >= BASE) && (a <= BASE + 32'd15);
  endfunction

  function automatic logic [31:0] modelStatus();
    logic [31:0] s;
    s      = '0;
    s[0]   = m_active;
    s[1]   = (mq.size() == D);
    s[2]   = (mq.size() == 0);
    s[3]   = m_ovf;
    s[8:4] = 5'(mq.size());
    return s;
  endfunction

  function automatic logic [31:0] modelRead(input logic [31:0] a);
    if (!modelSel(a))     return '0;
    if (a[3:2] == 2'd1)   return modelStatus();
    return '0;
  endfunction

  // One clock edge of the reference: advance/finish the frame on the line,
  // start a new one from the queue if the line was idle, then apply the store.
  function automatic void modelStep(input logic we, input logic [31:0] a,
                                    input logic [31:0] d);
    bit push;
    bit clr;
    bit do_pop;
    bit push_ok;
    int sz;
    push    = we && modelSel(a) && (a[3:2] == 2'd0);
    clr     = we && modelSel(a) && (a[3:2] == 2'd2);
    sz      = mq.size();
    do_pop  = !m_active && (sz > 0);
    push_ok = push && ((sz < D) || do_pop);
    if (m_active) begin
      m_t++;
      if (m_t == 10 * N) m_active = 1'b0;
    end else if (do_pop) begin
      m_byte   = mq.pop_front();
      m_active = 1'b1;
      m_t      = 0;
    end
    if (push_ok) mq.push_back(d[7:0]);
    if (push && !push_ok) m_ovf = 1'b1;
    else if (clr)         m_ovf = 1'b0;
  endfunction

  // Called just after a falling edge: drive, check, step model, next cycle.
  task automatic applyStimulus(input logic we, input logic [31:0] a,
                               input logic [31:0] d);
    MemWrite   = we;
    Mem_WrAddr = a;
    Mem_WrData = d;
    #1;
    checkOutput("tx", 32'(tx), 32'(modelTx()));
    checkOutput("irq", 32'(irq), 32'((mq.size() == 0) && !m_active));
    checkOutput("sel", 32'(sel), 32'(modelSel(a)));
    checkOutput("rd_data", rd_data, modelRead(a));
    if (prev_tx && !tx) fall_q.push_back(cyc);
    prev_tx = tx;
    modelStep(we, a, d);
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, BASE + 32'd4, '0);
  endtask

  task automatic expectStatus(input string tag, input logic [31:0] value);
    MemWrite   = 1'b0;
    Mem_WrAddr = BASE + 32'd4;
    #1;
    checkOutput(tag, rd_data, value);
    applyStimulus(1'b0, BASE + 32'd4, '0);
  endtask

  task automatic waitDrained(input string tag, input int budget);
    int k;
    k = 0;
    while ((m_active || mq.size() != 0) && k < budget) begin
      applyStimulus(1'b0, BASE + 32'd4, '0);
      k++;
    end
    checkOutput(tag, 32'(m_active || mq.size() != 0), 32'd0);
  endtask

  initial begin
    int w;
    int t0;
    int gap;
    int k;
    logic [31:0] a;
    logic        we;

    modelReset();
    #1 reset = 1'b0;

    // Reset state
    MemWrite   = 1'b0;
    Mem_WrAddr = BASE + 32'd4;
    @(negedge clk);
    #1;
    checkOutput("rst_tx", 32'(tx), 32'd1);
    checkOutput("rst_irq", 32'(irq), 32'd1);
    checkOutput("rst_sel", 32'(sel), 32'd1);
    checkOutput("rst_status", rd_data, 32'h0000_0004);
    @(negedge clk);
    reset = 1'b1;
    idleCycles(4);

    // Address decode and the reserved register
    MemWrite   = 1'b0;
    Mem_WrAddr = BASE + 32'd4;
    #1;
    checkOutput("dec_sel_in", 32'(sel), 32'd1);
    checkOutput("dec_rd_in", rd_data, 32'h0000_0004);
    Mem_WrAddr = BASE + 32'd16;
    #1;
    checkOutput("dec_sel_out", 32'(sel), 32'd0);
    checkOutput("dec_rd_out", rd_data, 32'd0);
    applyStimulus(1'b0, BASE + 32'd16, '0);
    applyStimulus(1'b1, BASE + 32'd12, 32'hFFFF_FFFF);
    expectStatus("dec_reserved", 32'h0000_0004);

    // Single frame 0xA5: start bit begins two cycles after the store cycle
    fall_q.delete();
    w = cyc;
    applyStimulus(1'b1, BASE, 32'h0000_00A5);
    idleCycles(46);
    checkOutput("frame_start", (fall_q.size() > 0) ? 32'(fall_q[0] - w) : 32'hFFFF_FFFF, 32'd2);

    // Back-to-back frames: second start bit 10*N+1 cycles after the first
    fall_q.delete();
    applyStimulus(1'b1, BASE, 32'h0000_0055);
    applyStimulus(1'b1, BASE, 32'h0000_000F);
    idleCycles(95);
    gap = -1;
    if (fall_q.size() > 0) begin
      t0 = fall_q[0];
      foreach (fall_q[i]) begin
        if (gap < 0 && fall_q[i] > t0 + 9 * N) gap = fall_q[i] - t0;
      end
    end
    checkOutput("b2b_gap", 32'(gap), 32'd41);

    // Overflow while busy, then CLEAR
    applyStimulus(1'b1, BASE, $urandom);
    idleCycles(3);
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, BASE, $urandom);
    expectStatus("ovf_status", 32'h0000_004B);
    applyStimulus(1'b1, BASE + 32'd8, '0);
    expectStatus("ovf_cleared", 32'h0000_0043);

    // Push on the exact edge the FSM pops from a full FIFO
    k = 0;
    while (!(!m_active && mq.size() == D) && k < 200) begin
      applyStimulus(1'b0, BASE + 32'd4, '0);
      k++;
    end
    checkOutput("full_pop_reached", 32'(!m_active && mq.size() == D), 32'd1);
    applyStimulus(1'b1, BASE, $urandom);
    expectStatus("full_pop_status", 32'h0000_0043);
    waitDrained("drain1", 600);

    // Reset in the middle of the data bits of 0x00, with another byte queued
    applyStimulus(1'b1, BASE, 32'h0000_0000);
    applyStimulus(1'b1, BASE, 32'h0000_00C3);
    k = 0;
    while (!(m_active && m_t >= N + 2) && k < 20) begin
      applyStimulus(1'b0, BASE + 32'd4, '0);
      k++;
    end
    checkOutput("mid_data_reached", 32'(m_active && m_t >= N + 2), 32'd1);
    MemWrite   = 1'b0;
    Mem_WrAddr = BASE + 32'd4;
    #2;
    reset = 1'b0;
    #1;
    checkOutput("mid_rst_tx", 32'(tx), 32'd1);
    checkOutput("mid_rst_irq", 32'(irq), 32'd1);
    modelReset();
    prev_tx = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    idleCycles(4);
    expectStatus("post_rst_status", 32'h0000_0004);
    idleCycles(20);

    // Randomised traffic
    for (int i = 0; i < 2500; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: a = BASE + 32'($urandom_range(0, 3));
        4, 5:       a = BASE + 32'd4 + 32'($urandom_range(0, 3));
        6:          a = BASE + 32'd8 + 32'($urandom_range(0, 3));
        7:          a = BASE + 32'd12 + 32'($urandom_range(0, 3));
        8:          a = BASE + 32'd16 + 32'($urandom_range(0, 15));
        default:    a = BASE - 32'($urandom_range(1, 16));
      endcase
      we = ($urandom_range(0, 99) < 12);
      applyStimulus(we, a, $urandom);
    end
    waitDrained("drain2", 1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
